pipe_hazard_sched: RTL
======================

Name: pipe_hazard_sched

Overview:
- Interlock scheduler for the 5-stage R-type pipeline (IF, ID, EX, MEM, WB), which has no forwarding paths.
- Keeps a shadow copy of the destination register and write-enable of every instruction in EX, MEM and WB.
- Detects read-after-write hazards for the instruction currently in ID.
- On a hazard it asserts stall to freeze the PC and IF/ID, and bubble to zero the ID/EX control fields. It also keeps stall and retire statistics.

Parameters:
- WB_BYPASS, 1: 1 means the RF writes before it reads in the same cycle, so the WB stage is excluded from hazard checks. 0 means WB is checked.
- CNT_W, 16: width of the saturating stall_cnt and retire_cnt counters.
- MAX_STALL, 3: longest legal run of consecutive stall cycles; a longer run sets err.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction (not a bubble).
- id_src_addr  in  5  rs field of the ID instruction.
- id_tar_addr  in  5  rt field of the ID instruction.
- id_uses_src  in  1  ID instruction reads rs.
- id_uses_tar  in  1  ID instruction reads rt.
- id_dst_addr  in  5  rd field of the ID instruction.
- id_reg_write  in  1  reg_write output of the main Control for the ID instruction.
- stall  out  1  combinational; hold the PC and the IF/ID register.
- bubble  out  1  combinational; equal to stall; force the ID/EX wb and ALU_OP fields to 0.
- stall_cnt  out  CNT_W  registered; total stall cycles, saturating.
- retire_cnt  out  CNT_W  registered; valid instructions leaving WB, saturating.
- err  out  1  registered, sticky; set when a stall run exceeds MAX_STALL.

Behaviour:
- Shadow slots: EX, MEM and WB, each holding {v, we, dst[4:0]}. "Live" means v && we && dst != 0.
- Update on every rising clk edge when rst = 0:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= {id_valid, id_reg_write, id_dst_addr} when stall = 0.
  - EX <= {0, 0, 0} (a bubble) when stall = 1.
- Hazard on rs: id_valid && id_uses_src && id_src_addr != 0 && id_src_addr matches the dst of a live EX or MEM slot, or of a live WB slot when WB_BYPASS = 0.
- Hazard on rt: the same rule using id_uses_tar and id_tar_addr.
- stall = (rs hazard OR rt hazard) AND NOT rst. The output is purely combinational from the slots and the ID inputs, so a hazard is asserted in the same cycle it appears.
- Resulting stall lengths for a back-to-back dependency:
  - WB_BYPASS = 1: 2 cycles.
  - WB_BYPASS = 0: 3 cycles.
  - Dependency at distance 2: 1 cycle with WB_BYPASS = 1, 2 cycles with WB_BYPASS = 0.
- Register $0 never causes a hazard, whether it is the source or the destination.
- An ID instruction that depends on two different in-flight writers stalls until the later (younger) writer clears. The stall is continuous, with no gap between the two causes.
- stall_cnt increments on each clk edge where stall = 1, and holds at all-ones.
- retire_cnt increments on each clk edge where WB.v = 1 (whether or not we is set), and holds at all-ones.
- Run counter: an internal counter of ceil(log2(MAX_STALL + 2)) bits.
  - Increments while stall = 1 and clears when stall = 0.
  - When it reaches MAX_STALL and stall is still 1, err <= 1.
  - err stays set until reset.
- Reset (synchronous):
  - All slots, both counters, the run counter and err go to 0.
  - stall and bubble are forced to 0 while rst = 1.
  - A reset asserted during a stall takes effect at the next edge. The following cycle then sees empty slots and therefore no stall.

Decomposition:
- Shared package pipe_pkg holds:
  - REG_ZERO = 5'd0.
  - The shadow-slot typedef {v, we, dst[4:0]}.
  - Stage index constants S_EX = 0, S_MEM = 1, S_WB = 2.
- Sub-module hazard_cmp (one address compared against one slot, giving a live-match bit) is instantiated six times: rs and rt against each of EX, MEM and WB. The WB instances are masked by WB_BYPASS.
- Everything else stays inline.

Test Plan:
- add $3,$1,$2 followed immediately by sub $5,$3,$4:
  - WB_BYPASS = 1: stall high exactly 2 cycles, EX receives 2 bubbles, stall_cnt = 2.
  - WB_BYPASS = 0: stall high exactly 3 cycles, stall_cnt = 3, err stays 0.
- add $0,$1,$2 then or $6,$0,$0, and separately two independent instructions ($3 <- $1,$2 then $4 <- $5,$6): stall never asserts, retire_cnt = 2 four cycles after the second instruction is issued.
- add $3,...; add $4,...; sub $7,$3,$4 with WB_BYPASS = 1: a single continuous stall of 2 cycles, with no gap between the $3 and $4 causes.
- rst pulsed for 1 cycle during the second stall cycle of the first scenario: stall = 0 during reset; slots, counters and err are 0 after reset; no stall on the following cycle.
- CNT_W = 4 with 20 independent instructions: retire_cnt saturates at 15. A forced never-clearing hazard (EX slot injected while ID held constant) with MAX_STALL = 3 sets err on the 4th stall edge, and err stays 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline interlock scheduler.
package pipe_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned S_EX      = 0;
  localparam int unsigned S_MEM     = 1;
  localparam int unsigned S_WB      = 2;
  localparam int unsigned NUM_SLOTS = 3;

  typedef struct packed {
    logic       v;
    logic       we;
    logic [4:0] dst;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{v: 1'b0, we: 1'b0, dst: REG_ZERO};

  // A slot only matters if it holds a real instruction that writes a non-$0 register.
  function automatic logic slot_live(slot_t s);
    return s.v && s.we && (s.dst != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Compares one source register address against one shadow slot.
module hazard_cmp
  import pipe_pkg::*;
(
  input  slot_t      slot,
  input  logic [4:0] addr,
  output logic       hit
);

  assign hit = slot_live(slot) && (addr == slot.dst);

endmodule

// File: rtl/pipe_hazard_sched.sv
// RAW interlock scheduler: tracks EX/MEM/WB destinations and stalls ID on a dependency.
module pipe_hazard_sched
  import pipe_pkg::*;
#(
  parameter bit          WB_BYPASS = 1'b1,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_STALL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_src_addr,
  input  logic [4:0]       id_tar_addr,
  input  logic             id_uses_src,
  input  logic             id_uses_tar,
  input  logic [4:0]       id_dst_addr,
  input  logic             id_reg_write,
  output logic             stall,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             err
);

  localparam int unsigned     RUN_W   = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);
  localparam logic [RUN_W-1:0] RUN_TOP = RUN_W'(MAX_STALL + 1);

  slot_t                slot_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] src_hit;
  logic [NUM_SLOTS-1:0] tar_hit;
  logic [NUM_SLOTS-1:0] stage_en;
  logic                 src_haz;
  logic                 tar_haz;
  logic [CNT_W-1:0]     stall_cnt_q;
  logic [CNT_W-1:0]     retire_cnt_q;
  logic [RUN_W-1:0]     run_q;
  logic                 err_q;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_cmp
    hazard_cmp u_src_cmp (
      .slot (slot_q[s]),
      .addr (id_src_addr),
      .hit  (src_hit[s])
    );
    hazard_cmp u_tar_cmp (
      .slot (slot_q[s]),
      .addr (id_tar_addr),
      .hit  (tar_hit[s])
    );
  end

  always_comb begin
    stage_en        = '1;
    // With write-before-read in the RF, WB results are already visible to ID.
    stage_en[S_WB]  = ~WB_BYPASS;
    src_haz = id_valid && id_uses_src && (id_src_addr != REG_ZERO) && (|(src_hit & stage_en));
    tar_haz = id_valid && id_uses_tar && (id_tar_addr != REG_ZERO) && (|(tar_hit & stage_en));
    stall   = (src_haz || tar_haz) && !rst;
  end

  assign bubble     = stall;
  assign stall_cnt  = stall_cnt_q;
  assign retire_cnt = retire_cnt_q;
  assign err        = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= SLOT_EMPTY;
      end
      stall_cnt_q  <= '0;
      retire_cnt_q <= '0;
      run_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      slot_q[S_WB]  <= slot_q[S_MEM];
      slot_q[S_MEM] <= slot_q[S_EX];
      if (stall) begin
        slot_q[S_EX] <= SLOT_EMPTY;
      end else begin
        slot_q[S_EX] <= '{v: id_valid, we: id_reg_write, dst: id_dst_addr};
      end

      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (slot_q[S_WB].v && (retire_cnt_q != '1)) begin
        retire_cnt_q <= retire_cnt_q + 1'b1;
      end

      // Run counter saturates one past the limit so it can never wrap back into range.
      if (stall) begin
        if (run_q != RUN_TOP) begin
          run_q <= run_q + 1'b1;
        end
        if (run_q >= RUN_MAX) begin
          err_q <= 1'b1;
        end
      end else begin
        run_q <= '0;
      end
    end
  end

endmodule
